// File: rtl/pulse_peak_detector.sv
// pulse_peak_detector
// Extracts pulses from the filtered ADC stream, which arrives one sample per
// clock. A pulse starts when a sample rises above THRESHOLD and ends when a
// sample falls below THRESHOLD-HYST. For each qualified pulse the peak
// amplitude, the timestamp of the first peak sample and the pulse width are
// presented through a one-deep valid/ready output register. Pulses that are
// too short, pile-ups that exceed MAX_WIDTH, and results lost to
// back-pressure are counted.
//
// Ports
//   clk         system clock, one filter sample per cycle
//   reset       asynchronous, active-low
//   in_data     filtered sample, signed
//   out_ready   consumer accepts the result
//   out_valid   result held in the output register
//   out_amp     signed peak amplitude
//   out_ts      timestamp of the first maximum sample
//   out_width   pulse length in samples (start inclusive, end exclusive)
//   busy        detector is not idle
//   drop_cnt    results lost to back-pressure (saturating)
//   pileup_cnt  pulses aborted at MAX_WIDTH (saturating)
//   short_cnt   pulses discarded below MIN_WIDTH (saturating)
module pulse_peak_detector #(
  parameter int DATA_W    = 14,
  parameter int TS_W      = 32,
  parameter int THRESHOLD = 200,
  parameter int HYST      = 20,
  parameter int MIN_WIDTH = 4,
  parameter int MAX_WIDTH = 200
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic signed [DATA_W-1:0] in_data,
  input  logic                     out_ready,
  output logic                     out_valid,
  output logic signed [DATA_W-1:0] out_amp,
  output logic [TS_W-1:0]          out_ts,
  output logic [7:0]               out_width,
  output logic                     busy,
  output logic [15:0]              drop_cnt,
  output logic [15:0]              pileup_cnt,
  output logic [15:0]              short_cnt
);

  localparam logic signed [DATA_W:0] HIGH = (DATA_W+1)'(THRESHOLD);
  localparam logic signed [DATA_W:0] LOW  = (DATA_W+1)'(THRESHOLD - HYST);
  localparam logic [7:0]             MINW = 8'(MIN_WIDTH);
  localparam logic [7:0]             MAXW = 8'(MAX_WIDTH);

  typedef enum logic [1:0] {IDLE, TRACK, SETTLE} state_t;

  state_t state, state_nx;

  logic signed [DATA_W-1:0] x_r;
  logic [TS_W-1:0]          ts_cnt, ts_r;
  logic signed [DATA_W-1:0] max_r;
  logic [TS_W-1:0]          max_ts_r;
  logic [7:0]               width_r;

  logic signed [DATA_W:0]   x_ext, max_ext;
  logic                     above, below, at_max, long_enough;
  logic                     start, grow, new_max, emit, short_hit, pile_hit;
  logic                     xfer;

  function automatic logic [15:0] sat_inc(input logic [15:0] c);
    return (c == '1) ? c : c + 16'd1;
  endfunction

  // Comparisons are done one bit wider than the sample.
  assign x_ext       = {x_r[DATA_W-1], x_r};
  assign max_ext     = {max_r[DATA_W-1], max_r};
  assign above       = x_ext > HIGH;
  assign below       = x_ext < LOW;
  assign at_max      = width_r == MAXW;
  assign long_enough = width_r >= MINW;
  assign xfer        = out_valid && out_ready;
  assign busy        = state != IDLE;

  // Input stage: sample and its timestamp travel together.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      x_r    <= '0;
      ts_r   <= '0;
      ts_cnt <= '0;
    end else begin
      x_r    <= in_data;
      ts_r   <= ts_cnt;
      ts_cnt <= ts_cnt + TS_W'(1);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:    if (above) state_nx = TRACK;
      TRACK: begin
        if (below)       state_nx = IDLE;
        else if (at_max) state_nx = SETTLE;
      end
      SETTLE:  if (below) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    start     = 1'b0;
    grow      = 1'b0;
    new_max   = 1'b0;
    emit      = 1'b0;
    short_hit = 1'b0;
    pile_hit  = 1'b0;
    unique case (state)
      IDLE: start = above;
      TRACK: begin
        if (below) begin
          emit      = long_enough;
          short_hit = !long_enough;
        end else if (at_max) begin
          pile_hit = 1'b1;
        end else begin
          grow    = 1'b1;
          new_max = x_ext > max_ext;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      max_r    <= '0;
      max_ts_r <= '0;
      width_r  <= '0;
    end else if (start) begin
      max_r    <= x_r;
      max_ts_r <= ts_r;
      width_r  <= 8'd1;
    end else if (grow) begin
      width_r <= width_r + 8'd1;
      if (new_max) begin
        max_r    <= x_r;
        max_ts_r <= ts_r;
      end
    end
  end

  // An emit into a full register that is not being drained is dropped;
  // an emit on a transfer edge replaces the leaving result.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      out_valid <= 1'b0;
      out_amp   <= '0;
      out_ts    <= '0;
      out_width <= '0;
      drop_cnt  <= '0;
    end else if (emit) begin
      if (out_valid && !out_ready) begin
        drop_cnt <= sat_inc(drop_cnt);
      end else begin
        out_valid <= 1'b1;
        out_amp   <= max_r;
        out_ts    <= max_ts_r;
        out_width <= width_r;
      end
    end else if (xfer) begin
      out_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pileup_cnt <= '0;
      short_cnt  <= '0;
    end else begin
      if (pile_hit)  pileup_cnt <= sat_inc(pileup_cnt);
      if (short_hit) short_cnt  <= sat_inc(short_cnt);
    end
  end

endmodule

// File: tb/tb_pulse_peak_detector.sv
// Testbench for pulse_peak_detector: directed scenarios followed by
// randomized pulse trains, all compared against a reference model that
// buffers each pulse's samples and reduces them when the pulse ends.
module tb_pulse_peak_detector;

  localparam int DATA_W = 14;
  localparam int TS_W   = 10;
  localparam int TS_MOD = 1 << TS_W;
  localparam int TH     = 200;
  localparam int HYST   = 20;
  localparam int LOW    = TH - HYST;
  localparam int MIN_W  = 4;
  localparam int MAX_W  = 200;

  logic                     clk = 1'b0;
  logic                     reset;
  logic signed [DATA_W-1:0] in_data;
  logic                     out_ready;
  logic                     out_valid;
  logic signed [DATA_W-1:0] out_amp;
  logic [TS_W-1:0]          out_ts;
  logic [7:0]               out_width;
  logic                     busy;
  logic [15:0]              drop_cnt, pileup_cnt, short_cnt;

  always #5 clk = ~clk;

  pulse_peak_detector #(
    .DATA_W(DATA_W), .TS_W(TS_W), .THRESHOLD(TH), .HYST(HYST),
    .MIN_WIDTH(MIN_W), .MAX_WIDTH(MAX_W)
  ) dut (
    .clk(clk), .reset(reset), .in_data(in_data), .out_ready(out_ready),
    .out_valid(out_valid), .out_amp(out_amp), .out_ts(out_ts),
    .out_width(out_width), .busy(busy), .drop_cnt(drop_cnt),
    .pileup_cnt(pileup_cnt), .short_cnt(short_cnt)
  );

  int checks = 0;
  int failures = 0;

  // Reference model state
  int m_x, m_ts, m_tscnt;
  int phase;                 // 0 idle, 1 inside pulse, 2 waiting for end of pile-up
  int p_amp[$];
  int p_ts[$];
  int e_valid, e_amp, e_ts, e_width;
  int e_drop, e_pile, e_short;

  task automatic check(input string tag, input longint got, input longint exp);
    checks++;
    if (got != exp) begin
      failures++;
      $display("FAIL %s got=%0d expected=%0d at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int sat16(input int c);
    return (c >= 65535) ? 65535 : c + 1;
  endfunction

  task automatic model_reset();
    m_x = 0; m_ts = 0; m_tscnt = 0; phase = 0;
    p_amp.delete(); p_ts.delete();
    e_valid = 0; e_amp = 0; e_ts = 0; e_width = 0;
    e_drop = 0; e_pile = 0; e_short = 0;
  endtask

  // One clock edge: judge the previously captured sample, update the output
  // register, then capture the sample that was on in_data.
  task automatic model_edge(input int din, input bit rdy);
    bit emit = 0;
    int amp = 0, ts = 0, w = 0;
    case (phase)
      0: if (m_x > TH) begin
        p_amp.delete(); p_ts.delete();
        p_amp.push_back(m_x); p_ts.push_back(m_ts);
        phase = 1;
      end
      1: begin
        if (m_x < LOW) begin
          if (p_amp.size() >= MIN_W) begin
            emit = 1;
            w = p_amp.size();
            amp = p_amp[0]; ts = p_ts[0];
            foreach (p_amp[i]) if (p_amp[i] > amp) begin
              amp = p_amp[i]; ts = p_ts[i];
            end
          end else begin
            e_short = sat16(e_short);
          end
          phase = 0;
        end else if (p_amp.size() == MAX_W) begin
          e_pile = sat16(e_pile);
          phase = 2;
        end else begin
          p_amp.push_back(m_x); p_ts.push_back(m_ts);
        end
      end
      default: if (m_x < LOW) phase = 0;
    endcase
    if (emit) begin
      if (e_valid != 0 && !rdy) e_drop = sat16(e_drop);
      else begin
        e_valid = 1; e_amp = amp; e_ts = ts; e_width = w;
      end
    end else if (e_valid != 0 && rdy) begin
      e_valid = 0;
    end
    m_x = din;
    m_ts = m_tscnt;
    m_tscnt = (m_tscnt + 1) % TS_MOD;
  endtask

  task automatic check_all();
    check("valid", out_valid, e_valid);
    check("busy", busy, (phase != 0) ? 1 : 0);
    if (e_valid != 0) begin
      check("amp", out_amp, e_amp);
      check("ts", out_ts, e_ts);
      check("width", out_width, e_width);
    end
    check("drop_cnt", drop_cnt, e_drop);
    check("pileup_cnt", pileup_cnt, e_pile);
    check("short_cnt", short_cnt, e_short);
  endtask

  task automatic step(input int din, input bit rdy);
    in_data = din[DATA_W-1:0];
    out_ready = rdy;
    @(posedge clk);
    model_edge(din, rdy);
    #1;
    check_all();
  endtask

  function automatic int rnd_low();
    if ($urandom_range(0, 9) == 0) return int'($urandom_range(0, 1000)) - 8192;
    return int'($urandom_range(0, 470)) - 290;
  endfunction

  function automatic int rnd_high();
    if ($urandom_range(0, 4) == 0) return int'($urandom_range(150, 230));
    return int'($urandom_range(181, 8191));
  endfunction

  function automatic bit rnd_rdy(input bit starve);
    if (starve) return $urandom_range(0, 4) == 0;
    return $urandom_range(0, 3) != 0;
  endfunction

  int  t0, nb, len;
  bit  starve;

  initial begin
    reset = 1'b0; in_data = '0; out_ready = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check("rst_valid", out_valid, 0);
    check("rst_amp", out_amp, 0);
    check("rst_ts", out_ts, 0);
    check("rst_width", out_width, 0);
    check("rst_busy", busy, 0);
    check("rst_cnts", {drop_cnt, pileup_cnt, short_cnt}, 0);
    reset = 1'b1;

    // Clean pulse
    step(0, 1); step(0, 1);
    t0 = m_tscnt;
    step(250, 1); step(400, 1); step(600, 1); step(500, 1); step(300, 1);
    step(150, 1);
    check("clean_latency", out_valid, 0);
    step(0, 1);
    check("clean_valid", out_valid, 1);
    check("clean_amp", out_amp, 600);
    check("clean_ts", out_ts, (t0 + 2) % TS_MOD);
    check("clean_width", out_width, 5);
    check("clean_cnts", {drop_cnt, pileup_cnt, short_cnt}, 0);
    step(0, 1); step(0, 1);

    // Hysteresis dip and flat top
    t0 = m_tscnt;
    step(250, 1); step(190, 1); step(185, 1); step(600, 1); step(600, 1);
    step(170, 1); step(0, 1);
    check("hyst_valid", out_valid, 1);
    check("hyst_amp", out_amp, 600);
    check("hyst_ts", out_ts, (t0 + 3) % TS_MOD);
    check("hyst_width", out_width, 5);
    step(0, 1); step(0, 1);

    // Short pulse
    step(300, 1); step(300, 1); step(300, 1); step(100, 1); step(0, 1); step(0, 1);
    check("short_cnt_one", short_cnt, 1);

    // Pile-up
    for (int i = 0; i < 210; i++) step(500, 1);
    step(0, 1);
    check("pile_busy_hold", busy, 1);
    step(0, 1);
    check("pile_busy_fall", busy, 0);
    check("pile_cnt_one", pileup_cnt, 1);
    step(0, 1);

    // Back-pressure: first result held, second dropped, third loads on a
    // transfer edge
    step(250, 0); step(400, 0); step(600, 0); step(500, 0); step(300, 0); step(150, 0);
    step(0, 0); step(0, 0);
    step(250, 0); step(400, 0); step(700, 0); step(500, 0); step(300, 0); step(150, 0);
    step(0, 0); step(0, 0);
    check("bp_held_amp", out_amp, 600);
    check("bp_drop_one", drop_cnt, 1);
    step(250, 0); step(400, 0); step(800, 0); step(500, 0); step(300, 0); step(150, 0);
    step(0, 1);
    check("bp_reload_valid", out_valid, 1);
    check("bp_reload_amp", out_amp, 800);
    check("bp_no_drop", drop_cnt, 1);
    step(0, 1); step(0, 1);

    // Asynchronous reset in the middle of a pulse
    step(250, 1); step(400, 1); step(600, 1); step(500, 1);
    check("mid_busy", busy, 1);
    #2 reset = 1'b0;
    #1;
    check("mid_rst_busy", busy, 0);
    check("mid_rst_valid", out_valid, 0);
    check("mid_rst_out", {out_amp, out_ts, out_width}, 0);
    check("mid_rst_cnts", {drop_cnt, pileup_cnt, short_cnt}, 0);
    in_data = '0;
    @(posedge clk);
    #1 reset = 1'b1;
    model_reset();
    for (int i = 0; i < 8; i++) step(0, 1);

    // Timestamp wrap inside a pulse
    for (int i = 0; i < 2 * TS_MOD && m_tscnt != TS_MOD - 2; i++) step(0, 1);
    step(250, 1); step(400, 1); step(600, 1); step(500, 1); step(300, 1); step(150, 1);
    step(0, 1);
    check("wrap_valid", out_valid, 1);
    check("wrap_ts", out_ts, 0);
    step(0, 1); step(0, 1);

    // Randomized pulse trains
    for (int seg = 0; seg < 300; seg++) begin
      starve = $urandom_range(0, 3) == 0;
      nb = $urandom_range(1, 6);
      for (int i = 0; i < nb; i++) step(rnd_low(), rnd_rdy(starve));
      if ($urandom_range(0, 19) == 0) len = $urandom_range(195, 215);
      else len = $urandom_range(1, 14);
      for (int i = 0; i < len; i++) step(rnd_high(), rnd_rdy(starve));
    end
    for (int i = 0; i < 6; i++) step(0, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
